// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch PC generator.
// Build macro PC_RVC_EN relaxes redirect alignment to 2-byte boundaries.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

`ifdef PC_RVC_EN
  localparam logic [1:0] ALIGN_MASK = 2'b01;
`else
  localparam logic [1:0] ALIGN_MASK = 2'b11;
`endif

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/pc_align_chk.sv
// Combinational alignment check of a redirect target against ALIGN_MASK.
// Alignment rule follows PC_RVC_EN through pc_pkg.
module pc_align_chk
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] addr_i,
  output logic            misaligned_o
);

  assign misaligned_o = |(addr_i & XLEN'(ALIGN_MASK));

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential advance, trap/redirect priority,
// valid/ready fetch request. Build macro PC_RVC_EN selects 2-byte redirect alignment.
//
// state | meaning
// BOOT  | first cycle out of reset, no request issued
// RUN   | fetch request valid at pc_o
// HALT  | fetching stopped, left only by trap or redirect
module pc_gen
  import pc_pkg::*;
#(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_VEC = XLEN'(PC_RESET_VEC),
  parameter int unsigned       INC       = PC_INC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_ready_i,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
  logic            misalign_q, misalign_d;
  logic            tgt_misaligned;

  pc_align_chk #(.XLEN(XLEN)) u_align_chk (
    .addr_i       (redirect_target_i),
    .misaligned_o (tgt_misaligned)
  );

  assign pc_next_o       = pc_q + XLEN'(INC);
  assign pc_o            = pc_q;
  assign fetch_valid_o   = (state_q == RUN);
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= BOOT;
      pc_q            <= RESET_VEC;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    if (trap_valid_i) begin
      pc_d    = trap_vec_i;
      state_d = RUN;
    end else if (redirect_valid_i) begin
      state_d = RUN;
      // A rejected target falls back to the trap handler and is reported once.
      if (tgt_misaligned) begin
        pc_d            = trap_vec_i;
        misalign_d      = 1'b1;
        misalign_addr_d = redirect_target_i;
      end else begin
        pc_d = redirect_target_i;
      end
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (halt_i) begin
            state_d = HALT;
          end else if (fetch_ready_i && !stall_i) begin
            pc_d = pc_next_o;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = BOOT;
      endcase
    end
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch front end; successor to the single-register PC. Holds the architectural fetch PC, advances it by one instruction per accepted fetch, and redirects it on branch/jump or trap with fixed priority. Drives the instruction-memory request through a valid/ready handshake and flags misaligned redirect targets. Sits between the execute/branch-resolve stage and the instruction fetch port.

## Interface
- XLEN, 32, address width in bits (≥ 16).
- RESET_VEC, 32'h0000_0000, PC value loaded on reset (XLEN bits; low alignment bits must be zero).
- INC, 4, byte increment per accepted fetch.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_ready_i  in  1  instruction memory accepts current request.
- stall_i  in  1  pipeline stall; blocks sequential advance only.
- halt_i  in  1  request to stop fetching (WFI/debug).
- redirect_valid_i  in  1  branch/jump taken this cycle.
- redirect_target_i  in  XLEN  redirect destination.
- trap_valid_i  in  1  exception/interrupt taken this cycle.
- trap_vec_i  in  XLEN  trap handler address (assumed aligned by CSR logic).
- fetch_valid_o  out  1  fetch request valid.
- pc_o  out  XLEN  current fetch PC.
- pc_next_o  out  XLEN  pc_o + INC, modulo 2^XLEN (combinational).
- misalign_o  out  1  one-cycle pulse: redirect target rejected.
- misalign_addr_o  out  XLEN  offending target, held until next misalign.

## Operation
- States: BOOT, RUN, HALT. Reset → BOOT.
- BOOT: fetch_valid_o=0; unconditionally → RUN next cycle.
- RUN: fetch_valid_o=1. HALT: fetch_valid_o=0.
- Per-cycle priority (highest first):
  1. trap_valid_i: pc ← trap_vec_i; state → RUN.
  2. redirect_valid_i, target aligned: pc ← target; state → RUN.
  3. redirect_valid_i, target misaligned: pc ← trap_vec_i; misalign_o=1; misalign_addr_o ← target; state → RUN.
  4. halt_i in RUN: pc held; state → HALT.
  5. RUN, fetch_valid_o & fetch_ready_i & !stall_i: pc ← pc + INC.
  6. otherwise pc held.
- Trap/redirect act in any state, including BOOT and HALT, and regardless of stall_i or fetch_ready_i (the in-flight request is abandoned).
- halt_i in HALT has no further effect; only trap or redirect leaves HALT.
- Sum is XLEN-bit modular: pc = 2^XLEN − INC advances to 0, no flag.

## Timing
- All state and pc_o registered; pc_o changes only on rising clk. Redirect/trap: new PC on pc_o one cycle after the input is sampled high.
- Sequential advance: one PC per cycle at full throughput with fetch_ready_i held high.
- fetch_valid_o, once high, stays high with pc_o stable until handshake, trap, redirect or halt.
- Reset values: pc_o=RESET_VEC, fetch_valid_o=0, misalign_o=0, misalign_addr_o=0, state BOOT. Asserting rst_n low mid-operation forces these immediately (asynchronously); first fetch two cycles after deassertion edge (BOOT then RUN).
- misalign_o high exactly one cycle, coincident with pc_o = trap_vec_i.

## Configuration
- PC_RVC_EN defined: alignment check requires target[0]=0 (16-bit instructions allowed); INC unchanged.
- PC_RVC_EN undefined: alignment check requires target[1:0]=2'b00.

## Structure
- Package pc_pkg: pc_state_e enum (BOOT, RUN, HALT), ALIGN_MASK constant selected by PC_RVC_EN, default RESET_VEC/INC localparams.
- Sub-module pc_align_chk: combinational XLEN-parametrised alignment checker returning misaligned flag; instantiated once for redirect_target_i.

## Test plan
- Reset, fetch_ready_i=1: pc_o=0 in BOOT with fetch_valid_o=0; then 0,4,8,12 on successive cycles.
- fetch_ready_i=0 for 3 cycles at pc_o=0x10: pc_o and fetch_valid_o held; advances to 0x14 the cycle after ready returns.
- stall_i=1 plus redirect_valid_i=1, target 0x200: pc_o=0x200 next cycle; simultaneous trap_valid_i with trap_vec_i=0x100 instead yields 0x100.
- Redirect to 0x202 without PC_RVC_EN: pc_o=trap_vec_i, misalign_o pulses 1 cycle, misalign_addr_o=0x202; with PC_RVC_EN: pc_o=0x202, no pulse.
- halt_i in RUN: fetch_valid_o drops, pc held; redirect to 0x40 resumes RUN with pc_o=0x40.
- XLEN=16, pc_o=0xFFFC, handshake: pc_o wraps to 0x0000; rst_n low mid-run restores RESET_VEC asynchronously.
